// File: rtl/cva6_pma_pkg.sv
// Shared types for the physical-memory-attribute table.
//   pma_attr_t  : {exec, cached, nonidem} attributes returned per lookup
//   pma_rule_t  : one table entry; base/length held at the widest supported
//                 address width so the struct can live in the package
//   pma_field_e : config field codes carried on cfg_field_i
package cva6_pma_pkg;

  localparam int unsigned PmaMaxAddrW = 64;

  typedef struct packed {
    logic exec;
    logic cached;
    logic nonidem;
  } pma_attr_t;

  typedef struct packed {
    logic [PmaMaxAddrW-1:0] base;
    logic [PmaMaxAddrW-1:0] length;
    pma_attr_t              attr;
    logic                   lock;
  } pma_rule_t;

  typedef enum logic [1:0] {
    FieldBase   = 2'd0,
    FieldLength = 2'd1,
    FieldAttr   = 2'd2,
    FieldCommit = 2'd3
  } pma_field_e;

  // Config-bus view of the attribute field: {lock, exec, cached, nonidem}.
  function automatic logic [3:0] rule_attr_word(pma_rule_t r);
    return {r.lock, r.attr};
  endfunction

endpackage

// File: rtl/cva6_pma_table_if.sv
// Bus bundle of the PMA table: config access port plus NrPorts lookup
// channels. Signal suffixes are relative to the table (slave):
//   cfg_*_i / cfg_*_o : config strobe, write data, read data, lock error
//   req_*             : lookup request valid/address, ready back
//   rsp_*             : response valid/ready, hit, rule index, attributes
interface cva6_pma_table_if #(
  parameter int unsigned NrRules   = 8,
  parameter int unsigned NrPorts   = 2,
  parameter int unsigned AddrWidth = 64
);
  localparam int unsigned IdxW = (NrRules > 1) ? $clog2(NrRules) : 1;

  logic                         cfg_req_i;
  logic                         cfg_we_i;
  logic [IdxW-1:0]              cfg_idx_i;
  logic [1:0]                   cfg_field_i;
  logic [AddrWidth-1:0]         cfg_wdata_i;
  logic [AddrWidth-1:0]         cfg_rdata_o;
  logic                         cfg_err_o;
  logic [NrPorts-1:0]           req_valid_i;
  logic [NrPorts*AddrWidth-1:0] req_addr_i;
  logic [NrPorts-1:0]           req_ready_o;
  logic [NrPorts-1:0]           rsp_valid_o;
  logic [NrPorts-1:0]           rsp_ready_i;
  logic [NrPorts-1:0]           rsp_hit_o;
  logic [NrPorts*IdxW-1:0]      rsp_rule_o;
  logic [NrPorts*3-1:0]         rsp_attr_o;

  modport master (
    output cfg_req_i, cfg_we_i, cfg_idx_i, cfg_field_i, cfg_wdata_i,
           req_valid_i, req_addr_i, rsp_ready_i,
    input  cfg_rdata_o, cfg_err_o, req_ready_o, rsp_valid_o,
           rsp_hit_o, rsp_rule_o, rsp_attr_o
  );

  modport slave (
    input  cfg_req_i, cfg_we_i, cfg_idx_i, cfg_field_i, cfg_wdata_i,
           req_valid_i, req_addr_i, rsp_ready_i,
    output cfg_rdata_o, cfg_err_o, req_ready_o, rsp_valid_o,
           rsp_hit_o, rsp_rule_o, rsp_attr_o
  );
endinterface

// File: rtl/cva6_pma_match.sv
// Combinational priority matcher for one address over the active table.
//   rules_i : active rule table
//   addr_i  : lookup address (zero-extended to PmaMaxAddrW)
//   hit_o   : some rule matched
//   rule_o  : lowest matching rule index, 0 on miss
//   attr_o  : attributes of that rule, DefaultAttr on miss
module cva6_pma_match
  import cva6_pma_pkg::*;
#(
  parameter int unsigned NrRules     = 8,
  parameter int unsigned IdxW        = 3,
  parameter logic [2:0]  DefaultAttr = 3'b001
) (
  input  pma_rule_t              rules_i [NrRules],
  input  logic [PmaMaxAddrW-1:0] addr_i,
  output logic                   hit_o,
  output logic [IdxW-1:0]        rule_o,
  output pma_attr_t              attr_o
);

  logic [NrRules-1:0] match;
  logic               unused_lock;

  // The end bound is formed one bit wider so a region reaching the top of
  // the address space cannot wrap around and cover low addresses.
  always_comb begin
    match       = '0;
    unused_lock = 1'b0;
    for (int i = 0; i < int'(NrRules); i++) begin
      match[i] = (rules_i[i].length != '0) &&
                 (addr_i >= rules_i[i].base) &&
                 ({1'b0, addr_i} < ({1'b0, rules_i[i].base} + {1'b0, rules_i[i].length}));
      unused_lock = unused_lock ^ rules_i[i].lock;
    end
  end

  // Walk from the top so the lowest-index hit is the one left standing.
  always_comb begin
    hit_o  = 1'b0;
    rule_o = '0;
    attr_o = pma_attr_t'(DefaultAttr);
    for (int i = int'(NrRules) - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_o  = 1'b1;
        rule_o = IdxW'(i);
        attr_o = rules_i[i].attr;
      end
    end
  end

endmodule

// File: rtl/cva6_pma_table.sv
// Run-time programmable PMA table with NrPorts independent lookup channels.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : cva6_pma_table_if slave -- config port (shadow writes,
//                  shadow reads, atomic commit, lock error) and per-channel
//                  request/response handshakes with one output register each
module cva6_pma_table
  import cva6_pma_pkg::*;
#(
  parameter int unsigned                  NrRules     = 8,
  parameter int unsigned                  NrPorts     = 2,
  parameter int unsigned                  AddrWidth   = 64,
  parameter logic [NrRules*AddrWidth-1:0] RstBase     = '0,
  parameter logic [NrRules*AddrWidth-1:0] RstLength   = '0,
  parameter logic [NrRules*4-1:0]         RstAttr     = '0,
  parameter logic [2:0]                   DefaultAttr = 3'b001
) (
  input logic             clk_i,
  input logic             rst_i,
  cva6_pma_table_if.slave bus
);

  localparam int unsigned IdxW = (NrRules > 1) ? $clog2(NrRules) : 1;

  pma_rule_t            shadow_q [NrRules];
  pma_rule_t            shadow_d [NrRules];
  pma_rule_t            active_q [NrRules];
  pma_rule_t            active_d [NrRules];
  logic [AddrWidth-1:0] cfg_rdata_q, cfg_rdata_d, rd_val;
  logic                 cfg_err_q, cfg_err_d;
  logic [IdxW-1:0]      idx;
  logic                 idx_ok;
  pma_field_e           field;

  function automatic pma_rule_t rst_rule(int unsigned i);
    pma_rule_t r;
    r        = '0;
    r.base   = PmaMaxAddrW'(RstBase[i*AddrWidth +: AddrWidth]);
    r.length = PmaMaxAddrW'(RstLength[i*AddrWidth +: AddrWidth]);
    r.attr   = pma_attr_t'(RstAttr[i*4 +: 3]);
    r.lock   = RstAttr[i*4+3];
    return r;
  endfunction

  assign idx   = bus.cfg_idx_i;
  assign field = pma_field_e'(bus.cfg_field_i);

  if (NrRules == (1 << IdxW)) begin : g_idx_full
    assign idx_ok = 1'b1;
  end else begin : g_idx_part
    assign idx_ok = (32'(idx) < NrRules);
  end

  always_comb begin
    rd_val = '0;
    if (idx_ok) begin
      case (field)
        FieldBase:   rd_val = shadow_q[idx].base[AddrWidth-1:0];
        FieldLength: rd_val = shadow_q[idx].length[AddrWidth-1:0];
        FieldAttr:   rd_val = AddrWidth'(rule_attr_word(shadow_q[idx]));
        default:     rd_val = '0;
      endcase
    end
  end

  // Lock is judged on the active copy, so a lock staged in the shadow only
  // starts protecting the entry once it has been committed.
  always_comb begin
    shadow_d    = shadow_q;
    active_d    = active_q;
    cfg_rdata_d = cfg_rdata_q;
    cfg_err_d   = 1'b0;
    if (bus.cfg_req_i) begin
      if (!bus.cfg_we_i) begin
        cfg_rdata_d = rd_val;
      end else if (field == FieldCommit) begin
        active_d = shadow_q;
      end else if (idx_ok) begin
        if (active_q[idx].lock) begin
          cfg_err_d = 1'b1;
        end else begin
          case (field)
            FieldBase:   shadow_d[idx].base   = PmaMaxAddrW'(bus.cfg_wdata_i);
            FieldLength: shadow_d[idx].length = PmaMaxAddrW'(bus.cfg_wdata_i);
            default: begin
              shadow_d[idx].attr = pma_attr_t'(bus.cfg_wdata_i[2:0]);
              shadow_d[idx].lock = bus.cfg_wdata_i[3];
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NrRules); i++) begin
        shadow_q[i] <= rst_rule(i);
        active_q[i] <= rst_rule(i);
      end
      cfg_rdata_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      cfg_rdata_q <= cfg_rdata_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign bus.cfg_rdata_o = cfg_rdata_q;
  assign bus.cfg_err_o   = cfg_err_q;

  for (genvar p = 0; p < NrPorts; p++) begin : g_port
    logic            m_hit;
    logic [IdxW-1:0] m_rule;
    pma_attr_t       m_attr;
    logic            valid_q, valid_d, hit_q, hit_d, ready, accept;
    logic [IdxW-1:0] rule_q, rule_d;
    pma_attr_t       attr_q, attr_d;

    cva6_pma_match #(
      .NrRules    (NrRules),
      .IdxW       (IdxW),
      .DefaultAttr(DefaultAttr)
    ) u_match (
      .rules_i(active_q),
      .addr_i (PmaMaxAddrW'(bus.req_addr_i[p*AddrWidth +: AddrWidth])),
      .hit_o  (m_hit),
      .rule_o (m_rule),
      .attr_o (m_attr)
    );

    assign ready  = !valid_q || bus.rsp_ready_i[p];
    assign accept = bus.req_valid_i[p] && ready;

    // A stalled response keeps what it captured; later commits never touch it.
    always_comb begin
      valid_d = valid_q;
      hit_d   = hit_q;
      rule_d  = rule_q;
      attr_d  = attr_q;
      if (accept) begin
        valid_d = 1'b1;
        hit_d   = m_hit;
        rule_d  = m_rule;
        attr_d  = m_attr;
      end else if (bus.rsp_ready_i[p]) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        valid_q <= 1'b0;
        hit_q   <= 1'b0;
        rule_q  <= '0;
        attr_q  <= '0;
      end else begin
        valid_q <= valid_d;
        hit_q   <= hit_d;
        rule_q  <= rule_d;
        attr_q  <= attr_d;
      end
    end

    assign bus.req_ready_o[p]             = ready;
    assign bus.rsp_valid_o[p]             = valid_q;
    assign bus.rsp_hit_o[p]               = hit_q;
    assign bus.rsp_rule_o[p*IdxW +: IdxW] = rule_q;
    assign bus.rsp_attr_o[p*3 +: 3]       = attr_q;
  end

endmodule
